// File: rtl/mfb_region_shakedown.sv
// Repacks MFB words with up to RX_REGIONS valid regions into words of TX_REGIONS regions.
// Valid regions are compacted in order into a slot buffer and drained TX_REGIONS at a time.
module mfb_region_shakedown #(
  parameter int RX_REGIONS  = 4,
  parameter int TX_REGIONS  = 2,
  parameter int REGION_SIZE = 8,
  parameter int BLOCK_SIZE  = 8,
  parameter int ITEM_WIDTH  = 8,
  parameter int META_WIDTH  = 1,
  localparam int RW  = REGION_SIZE*BLOCK_SIZE*ITEM_WIDTH,
  localparam int SPW = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1,
  localparam int EPW = (REGION_SIZE*BLOCK_SIZE > 1) ? $clog2(REGION_SIZE*BLOCK_SIZE) : 1
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [RX_REGIONS*RW-1:0]         RX_DATA,
  input  logic [RX_REGIONS*META_WIDTH-1:0] RX_META,
  input  logic [RX_REGIONS-1:0]            RX_SOF,
  input  logic [RX_REGIONS-1:0]            RX_EOF,
  input  logic [RX_REGIONS*SPW-1:0]        RX_SOF_POS,
  input  logic [RX_REGIONS*EPW-1:0]        RX_EOF_POS,
  input  logic [RX_REGIONS-1:0]            RX_REG_VLD,
  input  logic                             RX_SRC_RDY,
  output logic                             RX_DST_RDY,
  output logic [TX_REGIONS*RW-1:0]         TX_DATA,
  output logic [TX_REGIONS*META_WIDTH-1:0] TX_META,
  output logic [TX_REGIONS-1:0]            TX_SOF,
  output logic [TX_REGIONS-1:0]            TX_EOF,
  output logic [TX_REGIONS*SPW-1:0]        TX_SOF_POS,
  output logic [TX_REGIONS*EPW-1:0]        TX_EOF_POS,
  output logic [TX_REGIONS-1:0]            TX_REG_VLD,
  output logic                             TX_SRC_RDY,
  input  logic                             TX_DST_RDY
);

  localparam int CW = $clog2(RX_REGIONS + 1);
  localparam int IW = (RX_REGIONS > 1) ? $clog2(RX_REGIONS) : 1;

  logic [RX_REGIONS-1:0][RW-1:0]         data_r;
  logic [RX_REGIONS-1:0][META_WIDTH-1:0] meta_r;
  logic [RX_REGIONS-1:0]                 sof_r;
  logic [RX_REGIONS-1:0]                 eof_r;
  logic [RX_REGIONS-1:0][SPW-1:0]        sof_pos_r;
  logic [RX_REGIONS-1:0][EPW-1:0]        eof_pos_r;
  logic [CW-1:0]                         cnt_r;

  logic [RX_REGIONS-1:0][CW-1:0] pos_s;
  logic [RX_REGIONS-1:0][IW-1:0] src_idx_s;
  logic [CW-1:0]                 n_s;
  logic [CW-1:0]                 drain_s;
  logic                          rx_xfer_s;
  logic                          tx_xfer_s;

  // Handshakes: input accepted only when the buffer is empty or drains completely this cycle
  always_comb begin
    RX_DST_RDY = ~RESET & ((cnt_r == CW'(0)) | ((cnt_r <= CW'(TX_REGIONS)) & TX_DST_RDY));
    TX_SRC_RDY = (cnt_r != CW'(0));
    rx_xfer_s  = RX_SRC_RDY & RX_DST_RDY;
    tx_xfer_s  = TX_SRC_RDY & TX_DST_RDY;
    drain_s    = (cnt_r < CW'(TX_REGIONS)) ? cnt_r : CW'(TX_REGIONS);
  end

  // Compaction map: slot j takes the valid region whose rank among valid regions is j
  always_comb begin
    n_s = '0;
    for (int i = 0; i < RX_REGIONS; i++) begin
      pos_s[i] = n_s;
      n_s      = n_s + CW'(RX_REG_VLD[i]);
    end
    for (int j = 0; j < RX_REGIONS; j++) begin
      src_idx_s[j] = IW'(j);
      for (int i = 0; i < RX_REGIONS; i++) begin
        src_idx_s[j] = (RX_REG_VLD[i] && (pos_s[i] == CW'(j))) ? IW'(i) : src_idx_s[j];
      end
    end
  end

  // Region counter
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_r <= '0;
    end else if (rx_xfer_s) begin
      cnt_r <= n_s;
    end else if (tx_xfer_s) begin
      cnt_r <= cnt_r - drain_s;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Slot storage: a new word wins over the shift of a word that drains this cycle
  always_ff @(posedge CLK) begin
    if (rx_xfer_s) begin
      for (int j = 0; j < RX_REGIONS; j++) begin
        data_r[j]    <= RX_DATA[src_idx_s[j]*RW +: RW];
        meta_r[j]    <= RX_META[src_idx_s[j]*META_WIDTH +: META_WIDTH];
        sof_r[j]     <= RX_SOF[src_idx_s[j]];
        eof_r[j]     <= RX_EOF[src_idx_s[j]];
        sof_pos_r[j] <= RX_SOF_POS[src_idx_s[j]*SPW +: SPW];
        eof_pos_r[j] <= RX_EOF_POS[src_idx_s[j]*EPW +: EPW];
      end
    end else if (tx_xfer_s) begin
      for (int j = 0; j < RX_REGIONS; j++) begin
        data_r[j]    <= data_r[(j + TX_REGIONS < RX_REGIONS) ? j + TX_REGIONS : RX_REGIONS - 1];
        meta_r[j]    <= meta_r[(j + TX_REGIONS < RX_REGIONS) ? j + TX_REGIONS : RX_REGIONS - 1];
        sof_r[j]     <= sof_r[(j + TX_REGIONS < RX_REGIONS) ? j + TX_REGIONS : RX_REGIONS - 1];
        eof_r[j]     <= eof_r[(j + TX_REGIONS < RX_REGIONS) ? j + TX_REGIONS : RX_REGIONS - 1];
        sof_pos_r[j] <= sof_pos_r[(j + TX_REGIONS < RX_REGIONS) ? j + TX_REGIONS : RX_REGIONS - 1];
        eof_pos_r[j] <= eof_pos_r[(j + TX_REGIONS < RX_REGIONS) ? j + TX_REGIONS : RX_REGIONS - 1];
      end
    end else begin
      data_r    <= data_r;
      meta_r    <= meta_r;
      sof_r     <= sof_r;
      eof_r     <= eof_r;
      sof_pos_r <= sof_pos_r;
      eof_pos_r <= eof_pos_r;
    end
  end

  // TX view of the lowest slots; flags masked on regions beyond the count
  always_comb begin
    TX_DATA    = '0;
    TX_META    = '0;
    TX_SOF     = '0;
    TX_EOF     = '0;
    TX_SOF_POS = '0;
    TX_EOF_POS = '0;
    TX_REG_VLD = '0;
    for (int i = 0; i < TX_REGIONS; i++) begin
      TX_REG_VLD[i]                           = (CW'(i) < cnt_r);
      TX_DATA[i*RW +: RW]                     = data_r[i];
      TX_META[i*META_WIDTH +: META_WIDTH]     = meta_r[i];
      TX_SOF[i]                               = sof_r[i] & TX_REG_VLD[i];
      TX_EOF[i]                               = eof_r[i] & TX_REG_VLD[i];
      TX_SOF_POS[i*SPW +: SPW]                = sof_pos_r[i];
      TX_EOF_POS[i*EPW +: EPW]                = eof_pos_r[i];
    end
  end

endmodule

// File: tb/tb_mfb_region_shakedown.sv
// Directed bench for mfb_region_shakedown with RX_REGIONS=4, TX_REGIONS=2.
// Each region is generated from an 8-bit tag so its full tuple is known in advance.
module tb_mfb_region_shakedown;

  localparam int RXR = 4;
  localparam int TXR = 2;
  localparam int RW  = 512;
  localparam int SPW = 3;
  localparam int EPW = 6;
  localparam int TW  = RW + 1 + 1 + 1 + SPW + EPW;

  logic                 CLK = 1'b0;
  logic                 RESET = 1'b1;
  logic [RXR*RW-1:0]    RX_DATA = '0;
  logic [RXR-1:0]       RX_META = '0;
  logic [RXR-1:0]       RX_SOF = '0;
  logic [RXR-1:0]       RX_EOF = '0;
  logic [RXR*SPW-1:0]   RX_SOF_POS = '0;
  logic [RXR*EPW-1:0]   RX_EOF_POS = '0;
  logic [RXR-1:0]       RX_REG_VLD = '0;
  logic                 RX_SRC_RDY = 1'b0;
  logic                 RX_DST_RDY;
  logic [TXR*RW-1:0]    TX_DATA;
  logic [TXR-1:0]       TX_META;
  logic [TXR-1:0]       TX_SOF;
  logic [TXR-1:0]       TX_EOF;
  logic [TXR*SPW-1:0]   TX_SOF_POS;
  logic [TXR*EPW-1:0]   TX_EOF_POS;
  logic [TXR-1:0]       TX_REG_VLD;
  logic                 TX_SRC_RDY;
  logic                 TX_DST_RDY = 1'b0;

  int checks = 0;
  int errors = 0;

  mfb_region_shakedown #(
    .RX_REGIONS(RXR), .TX_REGIONS(TXR), .REGION_SIZE(8), .BLOCK_SIZE(8),
    .ITEM_WIDTH(8), .META_WIDTH(1)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .RX_DATA(RX_DATA), .RX_META(RX_META), .RX_SOF(RX_SOF), .RX_EOF(RX_EOF),
    .RX_SOF_POS(RX_SOF_POS), .RX_EOF_POS(RX_EOF_POS), .RX_REG_VLD(RX_REG_VLD),
    .RX_SRC_RDY(RX_SRC_RDY), .RX_DST_RDY(RX_DST_RDY),
    .TX_DATA(TX_DATA), .TX_META(TX_META), .TX_SOF(TX_SOF), .TX_EOF(TX_EOF),
    .TX_SOF_POS(TX_SOF_POS), .TX_EOF_POS(TX_EOF_POS), .TX_REG_VLD(TX_REG_VLD),
    .TX_SRC_RDY(TX_SRC_RDY), .TX_DST_RDY(TX_DST_RDY)
  );

  always #5 CLK = ~CLK;

  // Expected tuple {data, meta, sof, eof, sof_pos, eof_pos} for a tag
  function automatic logic [TW-1:0] tup(input logic [7:0] t);
    return {{64{t}}, t[0], t[1], t[2], t[5:3], t[7:2]};
  endfunction

  function automatic logic [TW-1:0] obs(input int i);
    return {TX_DATA[i*RW +: RW], TX_META[i], TX_SOF[i], TX_EOF[i],
            TX_SOF_POS[i*SPW +: SPW], TX_EOF_POS[i*EPW +: EPW]};
  endfunction

  task automatic load_rx(input logic [7:0] t3, input logic [7:0] t2, input logic [7:0] t1,
                         input logic [7:0] t0, input logic [3:0] vld);
    logic [7:0] tg [4];
    tg[0] = t0; tg[1] = t1; tg[2] = t2; tg[3] = t3;
    for (int k = 0; k < RXR; k++) begin
      RX_DATA[k*RW +: RW]      = {64{tg[k]}};
      RX_META[k]               = tg[k][0];
      RX_SOF[k]                = tg[k][1];
      RX_EOF[k]                = tg[k][2];
      RX_SOF_POS[k*SPW +: SPW] = tg[k][5:3];
      RX_EOF_POS[k*EPW +: EPW] = tg[k][7:2];
    end
    RX_REG_VLD = vld;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    tick();
    checks++; if (TX_SRC_RDY !== 1'b0) begin errors++; $display("FAIL rst_src_rdy act=%b exp=0", TX_SRC_RDY); end
    checks++; if (TX_REG_VLD !== 2'b00) begin errors++; $display("FAIL rst_reg_vld act=%b exp=00", TX_REG_VLD); end
    checks++; if ({TX_SOF, TX_EOF} !== 4'b0000) begin errors++; $display("FAIL rst_sof_eof act=%b exp=0000", {TX_SOF, TX_EOF}); end
    checks++; if (RX_DST_RDY !== 1'b0) begin errors++; $display("FAIL rst_rx_dst_rdy act=%b exp=0", RX_DST_RDY); end
    RESET = 1'b0;
    #1;
    checks++; if (RX_DST_RDY !== 1'b1) begin errors++; $display("FAIL rst_release_rdy act=%b exp=1", RX_DST_RDY); end
  endtask

  task automatic test_sparse();
    load_rx(8'h2B, 8'h00, 8'h16, 8'h00, 4'b1010);
    TX_DST_RDY = 1'b1;
    RX_SRC_RDY = 1'b1;
    #1;
    checks++; if (RX_DST_RDY !== 1'b1) begin errors++; $display("FAIL sparse_rdy_in act=%b exp=1", RX_DST_RDY); end
    tick();
    RX_SRC_RDY = 1'b0;
    #1;
    checks++; if (TX_REG_VLD !== 2'b11) begin errors++; $display("FAIL sparse_vld act=%b exp=11", TX_REG_VLD); end
    checks++; if (obs(0) !== tup(8'h16)) begin errors++; $display("FAIL sparse_tx0 act=%h exp=%h", obs(0), tup(8'h16)); end
    checks++; if (obs(1) !== tup(8'h2B)) begin errors++; $display("FAIL sparse_tx1 act=%h exp=%h", obs(1), tup(8'h2B)); end
    checks++; if (RX_DST_RDY !== 1'b1) begin errors++; $display("FAIL sparse_rdy_out act=%b exp=1", RX_DST_RDY); end
    tick();
    checks++; if (TX_SRC_RDY !== 1'b0) begin errors++; $display("FAIL sparse_drained act=%b exp=0", TX_SRC_RDY); end
  endtask

  task automatic test_full();
    load_rx(8'hD6, 8'hC1, 8'hB2, 8'hA4, 4'b1111);
    TX_DST_RDY = 1'b1;
    RX_SRC_RDY = 1'b1;
    tick();
    load_rx(8'h00, 8'h00, 8'h00, 8'h5E, 4'b0001);
    #1;
    checks++; if (TX_REG_VLD !== 2'b11) begin errors++; $display("FAIL full_w1_vld act=%b exp=11", TX_REG_VLD); end
    checks++; if ({obs(1), obs(0)} !== {tup(8'hB2), tup(8'hA4)}) begin errors++; $display("FAIL full_w1_data act=%h exp=%h", obs(0), tup(8'hA4)); end
    checks++; if (RX_DST_RDY !== 1'b0) begin errors++; $display("FAIL full_stall act=%b exp=0", RX_DST_RDY); end
    tick();
    checks++; if ({obs(1), obs(0)} !== {tup(8'hD6), tup(8'hC1)}) begin errors++; $display("FAIL full_w2_data act=%h exp=%h", obs(0), tup(8'hC1)); end
    checks++; if (RX_DST_RDY !== 1'b1) begin errors++; $display("FAIL full_w2_rdy act=%b exp=1", RX_DST_RDY); end
    tick();
    RX_SRC_RDY = 1'b0;
    #1;
    checks++; if (TX_REG_VLD !== 2'b01) begin errors++; $display("FAIL full_next_vld act=%b exp=01", TX_REG_VLD); end
    checks++; if (obs(0) !== tup(8'h5E)) begin errors++; $display("FAIL full_next_data act=%h exp=%h", obs(0), tup(8'h5E)); end
    tick();
    checks++; if (TX_SRC_RDY !== 1'b0) begin errors++; $display("FAIL full_drained act=%b exp=0", TX_SRC_RDY); end
  endtask

  task automatic test_backpressure();
    load_rx(8'hF6, 8'h36, 8'h21, 8'h14, 4'b0111);
    TX_DST_RDY = 1'b0;
    RX_SRC_RDY = 1'b1;
    tick();
    RX_SRC_RDY = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({TX_SRC_RDY, TX_REG_VLD, obs(1), obs(0)} !== {1'b1, 2'b11, tup(8'h21), tup(8'h14)}) begin
        errors++; $display("FAIL bp_hold cycle=%0d act_vld=%b exp_vld=11 act0=%h exp0=%h", c, TX_REG_VLD, obs(0), tup(8'h14));
      end
      if (c < 2) tick();
    end
    TX_DST_RDY = 1'b1;
    tick();
    checks++; if (TX_REG_VLD !== 2'b01) begin errors++; $display("FAIL bp_tail_vld act=%b exp=01", TX_REG_VLD); end
    checks++; if (obs(0) !== tup(8'h36)) begin errors++; $display("FAIL bp_tail_data act=%h exp=%h", obs(0), tup(8'h36)); end
    checks++; if ({TX_SOF[1], TX_EOF[1]} !== 2'b00) begin errors++; $display("FAIL bp_tail_flags act=%b exp=00", {TX_SOF[1], TX_EOF[1]}); end
    tick();
    checks++; if (TX_SRC_RDY !== 1'b0) begin errors++; $display("FAIL bp_drained act=%b exp=0", TX_SRC_RDY); end
  endtask

  task automatic test_back_to_back();
    TX_DST_RDY = 1'b1;
    load_rx(8'h00, 8'h00, 8'h62, 8'h71, 4'b0011);
    RX_SRC_RDY = 1'b1;
    tick();
    load_rx(8'h00, 8'h84, 8'h00, 8'h00, 4'b0100);
    #1;
    checks++; if ({TX_REG_VLD, obs(1), obs(0)} !== {2'b11, tup(8'h62), tup(8'h71)}) begin errors++; $display("FAIL b2b_w1 act=%h exp=%h", obs(0), tup(8'h71)); end
    checks++; if (RX_DST_RDY !== 1'b1) begin errors++; $display("FAIL b2b_rdy1 act=%b exp=1", RX_DST_RDY); end
    tick();
    load_rx(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    #1;
    checks++; if ({TX_REG_VLD, obs(0)} !== {2'b01, tup(8'h84)}) begin errors++; $display("FAIL b2b_w2 act=%h exp=%h", obs(0), tup(8'h84)); end
    tick();
    load_rx(8'h9A, 8'h00, 8'h00, 8'h93, 4'b1001);
    #1;
    checks++; if (TX_SRC_RDY !== 1'b0) begin errors++; $display("FAIL b2b_empty act=%b exp=0", TX_SRC_RDY); end
    checks++; if (RX_DST_RDY !== 1'b1) begin errors++; $display("FAIL b2b_empty_rdy act=%b exp=1", RX_DST_RDY); end
    tick();
    RX_SRC_RDY = 1'b0;
    #1;
    checks++; if ({TX_REG_VLD, obs(1), obs(0)} !== {2'b11, tup(8'h9A), tup(8'h93)}) begin errors++; $display("FAIL b2b_w4 act=%h exp=%h", obs(0), tup(8'h93)); end
    tick();
    checks++; if (TX_SRC_RDY !== 1'b0) begin errors++; $display("FAIL b2b_drained act=%b exp=0", TX_SRC_RDY); end
  endtask

  task automatic test_reset_mid_word();
    TX_DST_RDY = 1'b1;
    load_rx(8'hE6, 8'hE2, 8'hE4, 8'hE1, 4'b1111);
    RX_SRC_RDY = 1'b1;
    tick();
    RX_SRC_RDY = 1'b0;
    #1;
    checks++; if ({TX_REG_VLD, obs(1), obs(0)} !== {2'b11, tup(8'hE4), tup(8'hE1)}) begin errors++; $display("FAIL rstmid_w1 act=%h exp=%h", obs(0), tup(8'hE1)); end
    RESET = 1'b1;
    #1;
    checks++; if (RX_DST_RDY !== 1'b0) begin errors++; $display("FAIL rstmid_rdy act=%b exp=0", RX_DST_RDY); end
    tick();
    RESET = 1'b0;
    #1;
    checks++; if ({TX_SRC_RDY, TX_REG_VLD, TX_SOF, TX_EOF} !== 7'b0) begin errors++; $display("FAIL rstmid_flush act=%b exp=0000000", {TX_SRC_RDY, TX_REG_VLD, TX_SOF, TX_EOF}); end
    tick();
    checks++; if (TX_SRC_RDY !== 1'b0) begin errors++; $display("FAIL rstmid_no_tail act=%b exp=0", TX_SRC_RDY); end
    load_rx(8'h00, 8'h00, 8'h00, 8'h4F, 4'b0001);
    RX_SRC_RDY = 1'b1;
    tick();
    RX_SRC_RDY = 1'b0;
    #1;
    checks++; if ({TX_REG_VLD, obs(0)} !== {2'b01, tup(8'h4F)}) begin errors++; $display("FAIL rstmid_clean act=%h exp=%h", obs(0), tup(8'h4F)); end
    tick();
  endtask

  initial begin
    test_reset();
    test_sparse();
    test_full();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
